// File: rtl/dest_reader_if.sv
// Signal bundle between dest_reader, the two destination FIFOs and the
// counter reader. The slave modport is the dest_reader view.
interface dest_reader_if #(
  parameter int BW    = 6,
  parameter int CNT_W = 5
);
  logic             init;
  logic             idle_in;
  logic             D0_empty;
  logic             D1_empty;
  logic [BW-1:0]    D0_data_out;
  logic [BW-1:0]    D1_data_out;
  logic             D0_rd;
  logic             D1_rd;
  logic [BW-1:0]    data_out;
  logic             valid_out;
  logic             dest_error;
  logic             req;
  logic [1:0]       idx;
  logic             cnt_valid;
  logic [CNT_W-1:0] cnt_out;

  modport slave (
    input  init, idle_in, D0_empty, D1_empty, D0_data_out, D1_data_out,
           req, idx,
    output D0_rd, D1_rd, data_out, valid_out, dest_error, cnt_valid, cnt_out
  );

  modport master (
    output init, idle_in, D0_empty, D1_empty, D0_data_out, D1_data_out,
           req, idx,
    input  D0_rd, D1_rd, data_out, valid_out, dest_error, cnt_valid, cnt_out
  );
endinterface

// File: rtl/dest_reader.sv
// Egress consumer for destination FIFOs D0/D1: round-robin pops, registered
// output stream, destination-ID check and saturating per-dest/per-VC counters.
module dest_reader #(
  parameter int BW    = 6,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  dest_reader_if.slave bus
);
  localparam int VC_BIT  = BW - 1;
  localparam int DST_BIT = BW - 2;

  typedef enum logic {ST_ACTIVE = 1'b0, ST_DONE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rr;
  logic             w_pop0;
  logic             w_pop1;
  logic             w_pop;
  logic             r_vld_p1;
  logic             r_src_p1;
  logic [BW-1:0]    w_word_p1;
  logic [1:0]       w_cidx_p1;
  logic             w_mis_p1;
  logic [BW-1:0]    r_data_p2;
  logic             r_vld_p2;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt [4];
  logic             r_cnt_vld;
  logic [CNT_W-1:0] r_cnt_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACTIVE;
    else       r_state <= w_state_nxt;
  end

  // DONE only once nothing is queued or in flight; any new word wakes us up
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACTIVE:
        if (bus.idle_in && bus.D0_empty && bus.D1_empty && !r_vld_p1)
          w_state_nxt = ST_DONE;
      ST_DONE:
        if (!bus.D0_empty || !bus.D1_empty)
          w_state_nxt = ST_ACTIVE;
    endcase
  end

  always_comb begin
    w_pop0 = 1'b0;
    w_pop1 = 1'b0;
    if (!reset && r_state == ST_ACTIVE) begin
      if (!bus.D0_empty && (bus.D1_empty || !r_rr)) w_pop0 = 1'b1;
      else if (!bus.D1_empty)                        w_pop1 = 1'b1;
    end
  end

  assign w_pop     = w_pop0 | w_pop1;
  assign bus.D0_rd = w_pop0;
  assign bus.D1_rd = w_pop1;

  always_ff @(posedge clk) begin
    if (reset)      r_rr <= 1'b0;
    else if (w_pop) r_rr <= w_pop0;
  end

  // stage p1: FIFO read data arrives, word is checked and counted
  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= w_pop;
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_src_p1 <= w_pop1;
  end

  assign w_word_p1 = r_src_p1 ? bus.D1_data_out : bus.D0_data_out;
  assign w_cidx_p1 = {r_src_p1, w_word_p1[VC_BIT]};
  assign w_mis_p1  = (w_word_p1[DST_BIT] != r_src_p1);

  always_ff @(posedge clk) begin
    if (reset || bus.init)         r_err <= 1'b0;
    else if (r_vld_p1 && w_mis_p1) r_err <= 1'b1;
  end

  // init beats a simultaneous capture, so the counter ends at zero
  always_ff @(posedge clk) begin
    if (reset || bus.init) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (r_vld_p1) begin
      r_cnt[w_cidx_p1] <= sat_inc(r_cnt[w_cidx_p1]);
    end
  end

  // stage p2: registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_data_p2 <= w_word_p1;
    end
  end

  // counter read port answers only once the fabric has drained
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_vld <= 1'b0;
      r_cnt_out <= '0;
    end else if (r_state == ST_DONE && bus.req) begin
      r_cnt_vld <= 1'b1;
      r_cnt_out <= r_cnt[bus.idx];
    end else begin
      r_cnt_vld <= 1'b0;
    end
  end

  assign bus.data_out   = r_data_p2;
  assign bus.valid_out  = r_vld_p2;
  assign bus.dest_error = r_err;
  assign bus.cnt_valid  = r_cnt_vld;
  assign bus.cnt_out    = r_cnt_out;
endmodule

// File: tb/tb_dest_reader.sv
// Bench for dest_reader: FIFO models, a scoreboard/counter model, directed
// vector tables for the corner cases and a randomized traffic phase.
module tb_dest_reader;
  localparam int BW    = 6;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_reader_if #(.BW(BW), .CNT_W(CNT_W)) bus ();
  dest_reader #(.BW(BW), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [1:0] idx; logic [4:0] cnt; } rd_vec_t;
  typedef struct { logic src; logic [5:0] word; logic err; logic [1:0] idx; logic [4:0] cnt; } tx_vec_t;

  int total = 0;
  int bad   = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];

  // reference model: pop appears on the stream two cycles later
  logic       pipe_v1, pipe_v2, pipe_s1;
  logic [5:0] pipe_w1, pipe_w2;
  int         mcnt [4];
  logic       merr;
  logic       cv_pend;
  logic [4:0] cnt_hold;
  logic       done_known;
  int         cyc = 0;
  logic [5:0] out_log[$];
  int         out_cyc[$];

  rd_vec_t    rd_tab [4];
  rd_vec_t    zero_tab [4];
  tx_vec_t    tx_tab [3];
  logic [5:0] rr_exp [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic s, input logic [5:0] w);
    if (s) q1.push_back(w);
    else   q0.push_back(w);
    bus.D0_empty = (q0.size() == 0);
    bus.D1_empty = (q1.size() == 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    merr = 1'b0;
  endtask

  task automatic step();
    logic       p0, p1;
    logic [5:0] w;
    int         ci;
    @(negedge clk);
    cyc++;
    p0 = bus.D0_rd;
    p1 = bus.D1_rd;
    check("rd_exclusive", {31'd0, p0 & p1}, 0);
    check("rd0_on_empty", {31'd0, p0 && q0.size() == 0}, 0);
    check("rd1_on_empty", {31'd0, p1 && q1.size() == 0}, 0);
    if (reset) check("rd_in_reset", {30'd0, p0, p1}, 0);
    check("valid_out", {31'd0, bus.valid_out}, {31'd0, pipe_v2});
    if (pipe_v2) check("data_out", {26'd0, bus.data_out}, {26'd0, pipe_w2});
    if (bus.valid_out === 1'b1) begin
      out_log.push_back(bus.data_out);
      out_cyc.push_back(cyc);
    end
    check("dest_error", {31'd0, bus.dest_error}, {31'd0, merr});
    check("cnt_valid", {31'd0, bus.cnt_valid}, {31'd0, cv_pend});
    check("cnt_out", {27'd0, bus.cnt_out}, {27'd0, cnt_hold});
    w = '0;
    if (reset) begin
      model_clear();
      pipe_v1 = 1'b0; pipe_v2 = 1'b0;
      cv_pend = 1'b0; cnt_hold = '0;
      if (p0 && q0.size() > 0) w = q0.pop_front();
      if (p1 && q1.size() > 0) w = q1.pop_front();
    end else begin
      if (bus.req && done_known) begin
        cv_pend  = 1'b1;
        cnt_hold = 5'(mcnt[bus.idx]);
      end else begin
        cv_pend = 1'b0;
      end
      if (bus.init) begin
        model_clear();
      end else if (pipe_v1) begin
        ci = {30'd0, pipe_s1, pipe_w1[5]};
        if (mcnt[ci] < 31) mcnt[ci]++;
        if (pipe_w1[4] != pipe_s1) merr = 1'b1;
      end
      pipe_v2 = pipe_v1;
      pipe_w2 = pipe_w1;
      pipe_v1 = 1'b0;
      if (p0 && q0.size() > 0) begin w = q0.pop_front(); pipe_v1 = 1'b1; pipe_s1 = 1'b0; end
      else if (p1 && q1.size() > 0) begin w = q1.pop_front(); pipe_v1 = 1'b1; pipe_s1 = 1'b1; end
      pipe_w1 = w;
    end
    @(posedge clk);
    #1;
    if (p0) bus.D0_data_out = w;
    if (p1) bus.D1_data_out = w;
    bus.D0_empty = (q0.size() == 0);
    bus.D1_empty = (q1.size() == 0);
    #1;
  endtask

  task automatic readout(input string name, input logic [1:0] i, input logic [4:0] e);
    bus.idx = i;
    bus.req = 1'b1;
    step();
    check({name, "_valid"}, {31'd0, bus.cnt_valid}, 1);
    check(name, {27'd0, bus.cnt_out}, {27'd0, e});
    bus.req = 1'b0;
  endtask

  task automatic drain_to_done();
    bus.idle_in = 1'b1;
    repeat (3) step();
    done_known = 1'b1;
  endtask

  task automatic to_active();
    done_known  = 1'b0;
    bus.idle_in = 1'b0;
    bus.req     = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic       found;
    logic       s;
    logic [5:0] w;

    rr_exp   = '{6'b000000, 6'b010000, 6'b100000, 6'b110000, 6'b000001, 6'b010001};
    rd_tab[0] = '{2'd0, 5'd2}; rd_tab[1] = '{2'd1, 5'd1};
    rd_tab[2] = '{2'd2, 5'd2}; rd_tab[3] = '{2'd3, 5'd1};
    for (int i = 0; i < 4; i++) zero_tab[i] = '{2'(i), 5'd0};
    tx_tab[0] = '{1'b0, 6'b010011, 1'b1, 2'd0, 5'd3};
    tx_tab[1] = '{1'b1, 6'b110101, 1'b1, 2'd3, 5'd2};
    tx_tab[2] = '{1'b1, 6'b000111, 1'b1, 2'd2, 5'd3};

    bus.init = 1'b0; bus.idle_in = 1'b0; bus.req = 1'b0; bus.idx = 2'd0;
    bus.D0_empty = 1'b1; bus.D1_empty = 1'b1;
    bus.D0_data_out = '0; bus.D1_data_out = '0;
    pipe_v1 = 1'b0; pipe_v2 = 1'b0; pipe_s1 = 1'b0; pipe_w1 = '0; pipe_w2 = '0;
    cv_pend = 1'b0; cnt_hold = '0; done_known = 1'b0;
    model_clear();
    reset = 1'b1;
    @(posedge clk);
    #2;

    // reset with both FIFOs holding a word
    push(1'b0, 6'b000010);
    push(1'b1, 6'b010010);
    repeat (2) step();
    check("rst_data_out", {26'd0, bus.data_out}, 0);
    check("rst_rd", {30'd0, bus.D0_rd, bus.D1_rd}, 0);
    check("rst_cnt_out", {27'd0, bus.cnt_out}, 0);
    reset = 1'b0;
    #1;
    check("first_pop_d0", {30'd0, bus.D0_rd, bus.D1_rd}, 2);
    repeat (2) step();
    check("first_word_valid", {31'd0, bus.valid_out}, 1);
    check("first_word", {26'd0, bus.data_out}, 6'b000010);
    repeat (4) step();

    // round-robin over three words per FIFO
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    out_log.delete();
    out_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      push(1'b0, rr_exp[2*i]);
      push(1'b1, rr_exp[2*i+1]);
    end
    repeat (10) step();
    check("rr_count", out_log.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < out_log.size()) check("rr_word", {26'd0, out_log[i]}, {26'd0, rr_exp[i]});
    if (out_cyc.size() == 6) check("rr_back_to_back", out_cyc[5] - out_cyc[0], 5);
    check("rr_dest_error", {31'd0, bus.dest_error}, 0);

    // counter readout, back-to-back requests
    drain_to_done();
    for (int i = 0; i < 4; i++) readout("rr_cnt", rd_tab[i].idx, rd_tab[i].cnt);
    step();
    check("rr_cnt_valid_end", {31'd0, bus.cnt_valid}, 0);

    // destination check vectors, then init clear
    for (int i = 0; i < 3; i++) begin
      to_active();
      push(tx_tab[i].src, tx_tab[i].word);
      repeat (5) step();
      drain_to_done();
      readout("mis_cnt", tx_tab[i].idx, tx_tab[i].cnt);
      check("mis_err", {31'd0, bus.dest_error}, {31'd0, tx_tab[i].err});
    end
    bus.init = 1'b1;
    step();
    bus.init = 1'b0;
    check("init_err", {31'd0, bus.dest_error}, 0);
    for (int i = 0; i < 4; i++) readout("init_cnt", zero_tab[i].idx, zero_tab[i].cnt);

    // saturation, and requests while active are ignored
    to_active();
    for (int i = 0; i < 35; i++) push(1'b0, 6'b100000 | 6'(i % 16));
    repeat (2) step();
    for (int i = 0; i < 40; i++) begin
      bus.req = 1'b1;
      bus.idx = 2'($urandom_range(0, 3));
      step();
    end
    bus.req = 1'b0;
    check("sat_active_req", {31'd0, bus.cnt_valid}, 0);
    repeat (2) step();
    drain_to_done();
    readout("sat_cnt", 2'd1, 5'd31);

    // reset the cycle after D1_rd drops the in-flight word
    to_active();
    push(1'b1, 6'b010101);
    #1;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      if (bus.D1_rd) found = 1'b1;
      else           step();
    end
    check("mid_rst_rd1_seen", {31'd0, found}, 1);
    out_log.delete();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req = 1'b1;
    bus.idx = 2'd2;
    repeat (4) step();
    bus.req = 1'b0;
    check("mid_rst_no_valid", out_log.size(), 0);
    check("mid_rst_active", {31'd0, bus.cnt_valid}, 0);
    drain_to_done();
    for (int i = 0; i < 4; i++) readout("mid_rst_cnt", zero_tab[i].idx, zero_tab[i].cnt);

    // randomized traffic against the model
    to_active();
    push(1'b0, 6'b000001);
    push(1'b1, 6'b010001);
    repeat (2) step();
    for (int i = 0; i < 300; i++) begin
      for (int f = 0; f < 2; f++) begin
        s = f[0];
        if ((s ? q1.size() : q0.size()) < 6 && $urandom_range(0, 1) == 1) begin
          w = 6'($urandom);
          w[4] = ($urandom_range(0, 7) == 0) ? ~s : s;
          push(s, w);
        end
      end
      bus.req  = $urandom_range(0, 1) == 1;
      bus.idx  = 2'($urandom_range(0, 3));
      bus.init = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.init = 1'b0;
    bus.req  = 1'b0;
    repeat (20) step();
    drain_to_done();
    for (int i = 0; i < 4; i++) readout("rand_cnt", 2'(i), 5'(mcnt[i]));
    check("rand_err", {31'd0, bus.dest_error}, {31'd0, merr});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dest_reader.md
# dest_reader

Egress consumer for the two destination FIFOs (D0, D1) of the QoS fabric. It pops both FIFOs with round-robin arbitration and registers each popped word onto a single output stream. It checks that every word carries the destination ID of the FIFO it came from and keeps per-destination/per-VC word counters. A request/response port reads the counters once the fabric has drained.

## Interface
Parameters
- BW, 6: data word width. Bit BW-1 is the VC ID (0 = VC0, 1 = VC1). Bit BW-2 is the destination ID (0 = D0, 1 = D1).
- CNT_W, 5: width of each word counter.

Ports
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  synchronous clear of counters and error flag (level, one cycle is enough).
- idle_in  input  1  fabric idle indication from the condition FSM.
- D0_empty  input  1  D0 FIFO empty.
- D1_empty  input  1  D1 FIFO empty.
- D0_data_out  input  BW  D0 FIFO read data; valid the cycle after D0_rd.
- D1_data_out  input  BW  D1 FIFO read data; valid the cycle after D1_rd.
- D0_rd  output  1  pop D0 (combinational from state, pointer and empties).
- D1_rd  output  1  pop D1.
- data_out  output  BW  registered popped word.
- valid_out  output  1  data_out valid, one-cycle pulse per word.
- dest_error  output  1  sticky destination-mismatch flag.
- req  input  1  counter read request.
- idx  input  2  counter select: 0 = D0/VC0, 1 = D0/VC1, 2 = D1/VC0, 3 = D1/VC1.
- cnt_valid  output  1  cnt_out valid, one-cycle pulse.
- cnt_out  output  CNT_W  selected counter value.

## Operation
- The FSM has two states: ACTIVE and DONE. Reset enters ACTIVE.
- ACTIVE, arbitration (evaluated each cycle):
  - Only D0 non-empty: assert D0_rd.
  - Only D1 non-empty: assert D1_rd.
  - Both non-empty: pop the FIFO selected by the round-robin pointer rr.
  - After any pop, rr points to the other FIFO.
  - rr resets to D0.
  - D0_rd and D1_rd are never high together and never asserted on an empty FIFO.
- Capture:
  - A pop in cycle N registers the selected FIFO's data at the end of cycle N+1 into data_out, with valid_out = 1 in cycle N+2.
  - A 1-bit in-flight flag and a 1-bit source register track the pending word.
- Check:
  - If the captured word's bit BW-2 differs from its source FIFO, dest_error is set.
  - dest_error is sticky until reset or init.
  - The word is still output and counted under its source FIFO and the word's bit BW-1.
- Counters:
  - There are four CNT_W-bit counters, indexed by {source, bit BW-1}.
  - Each counter increments on capture and saturates at 2^CNT_W-1 (no wrap).
- ACTIVE -> DONE when idle_in = 1, D0_empty = 1, D1_empty = 1 and no word is in flight.
- DONE -> ACTIVE when either FIFO becomes non-empty. The pop is issued in the first ACTIVE cycle, not in DONE.
- DONE: no pops are issued and counters are frozen.
- Counter read:
  - In DONE, req = 1 in cycle N gives cnt_valid = 1 and cnt_out = counter[idx] in cycle N+1.
  - Back-to-back requests are allowed, one per cycle.
  - req in ACTIVE is ignored: cnt_valid stays 0.
- init:
  - Clears all counters and dest_error on the next edge.
  - State, rr and any in-flight word are unaffected; the in-flight word is still output and counted after the clear.
  - If init coincides with a capture, the clear wins and the counter ends at 0.
- Reset:
  - All outputs go to 0, state to ACTIVE, rr to D0, the in-flight flag to 0.
  - Reset mid-transfer drops the in-flight word; no valid_out is produced for it.

## Timing
- Reset values: D0_rd = D1_rd = 0 while reset is high. data_out = 0, valid_out = 0, dest_error = 0, cnt_valid = 0, cnt_out = 0, all counters = 0.
- Pop-to-valid_out latency: 2 cycles. Throughput: 1 word per cycle under continuous non-empty input.
- rd outputs are combinational. Everything else is registered.
- req-to-cnt_valid latency: 1 cycle. cnt_out holds its last value when cnt_valid = 0.
- DONE is entered at the earliest 1 cycle after the last valid_out condition is resolved, i.e. the edge after the final capture.

## Test plan
- Reset: assert reset with both FIFOs non-empty -> rd outputs 0; after release, the first pop is D0_rd (rr = D0); first valid_out 2 cycles later with D0's word.
- Round-robin: both FIFOs hold 3 words each (D0: 6'b000000, 6'b100000, 6'b000001; D1: 6'b010000, 6'b110000, 6'b010001) -> pops alternate D0, D1, D0, D1, D0, D1; six consecutive valid_out pulses in that order; dest_error = 0.
- Counter readout: after the above with idle_in = 1 -> DONE; req with idx = 0, 1, 2, 3 on consecutive cycles -> cnt_out = 2, 1, 2, 1 with cnt_valid high for 4 cycles.
- Mismatch: D0 delivers 6'b010011 -> dest_error = 1 and stays high; counter idx 0 increments by 1; init pulse -> dest_error = 0, counters 0.
- Saturation: 35 D0/VC1 words with CNT_W = 5 -> counter idx 1 = 31; req in ACTIVE -> cnt_valid stays 0.
- Reset mid-operation: reset asserted the cycle after D1_rd -> no valid_out for that word, all counters 0, state ACTIVE.
